// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo drain arbiter: state encoding, default
// widths and a modulo-increment helper usable with any queue count.
package fifo_arb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_QUEUE_BITS = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } arb_state_e;

    // (base + off) mod modulus, valid for base, off < modulus; works for
    // queue counts that are not a power of two.
    function automatic int wrap_add(input int base, input int off, input int modulus);
        int sum;
        sum = base + off;
        if (sum >= modulus) begin
            sum = sum - modulus;
        end
        return sum;
    endfunction

endpackage

// File: rtl/fifo_drain_arbiter_rr_select.sv
// rr_select: combinational round-robin search. Finds the first set request
// at or after start_i, wrapping modulo NUM_QUEUES. start_i must be below
// NUM_QUEUES.
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int NUM_QUEUES = 4,
    parameter int QUEUE_BITS = DEFAULT_QUEUE_BITS
) (
    input  logic [NUM_QUEUES-1:0] req_i,
    input  logic [QUEUE_BITS-1:0] start_i,
    output logic                  found_o,
    output logic [QUEUE_BITS-1:0] index_o
);

    logic [2*NUM_QUEUES-1:0] req_x2;
    logic [NUM_QUEUES-1:0]   rotated;
    logic [QUEUE_BITS-1:0]   offset;

    // Doubling the vector turns the wrapped search into a plain shift.
    assign req_x2  = {req_i, req_i};
    assign rotated = NUM_QUEUES'(req_x2 >> start_i);

    // Lowest set bit of the rotated vector is the closest requester.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        found_o = |rotated;
        offset  = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = QUEUE_BITS'(i);
            end
        end
        index_o = QUEUE_BITS'(wrap_add(int'(start_i), int'(offset), NUM_QUEUES));
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: drains NUM_QUEUES fifos into one valid/ready consumer,
// round-robin, at most MAX_BURST words per grant.
// Build option: define FIFO_ARB_STRICT_PRIO_EN to make fifo 0 the highest
// priority (search always starts at 0, rr_ptr frozen).
module fifo_drain_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_QUEUES = 4,
    parameter int QUEUE_BITS = DEFAULT_QUEUE_BITS,
    parameter int MAX_BURST  = 4,
    parameter int BURST_BITS = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_QUEUES-1:0]            fifo_empty,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] fifo_q,
    output logic [NUM_QUEUES-1:0]            read_enable,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [QUEUE_BITS-1:0]            grant_id,
    output logic                             busy
);

`ifdef FIFO_ARB_STRICT_PRIO_EN
    localparam bit STRICT_PRIO = 1'b1;
`else
    localparam bit STRICT_PRIO = 1'b0;
`endif

    arb_state_e              state_q, state_d;
    logic [QUEUE_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BURST_BITS-1:0]   burst_cnt_q, burst_cnt_d;
    logic [QUEUE_BITS-1:0]   grant_q, grant_d;
    logic [NUM_QUEUES-1:0]   read_en_q, read_en_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    logic                    found;
    logic [QUEUE_BITS-1:0]   found_idx;
    logic [QUEUE_BITS-1:0]   start_idx;
    logic                    granted_empty;
    logic                    accept;
    logic                    keep_burst;
    logic [QUEUE_BITS-1:0]   next_ptr;
    logic [NUM_QUEUES-1:0]   found_onehot;
    logic [NUM_QUEUES-1:0]   grant_onehot;

    assign start_idx     = STRICT_PRIO ? '0 : rr_ptr_q;
    assign granted_empty = fifo_empty[grant_q];
    assign accept        = out_valid_q & out_ready;
    assign keep_burst    = (burst_cnt_q < BURST_BITS'(MAX_BURST)) && !granted_empty;
    assign next_ptr      = QUEUE_BITS'(wrap_add(int'(grant_q), 1, NUM_QUEUES));
    assign found_onehot  = NUM_QUEUES'(1) << found_idx;
    assign grant_onehot  = NUM_QUEUES'(1) << grant_q;

    rr_select #(
        .NUM_QUEUES (NUM_QUEUES),
        .QUEUE_BITS (QUEUE_BITS)
    ) u_rr_select (
        .req_i   (~fifo_empty),
        .start_i (start_idx),
        .found_o (found),
        .index_o (found_idx)
    );

    // State and registered outputs; reset discards any word in flight.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of all the others.
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            grant_q     <= '0;
            read_en_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
            read_en_q   <= read_en_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state: grant, pulse, capture, hold until accepted, then continue or rotate.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found) state_d = READ;
            READ:    state_d = granted_empty ? IDLE : CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD:    if (accept) state_d = keep_burst ? READ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        grant_d     = grant_q;
        read_en_d   = '0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d     = found_idx;
                    burst_cnt_d = '0;
                    read_en_d   = found_onehot;
                end
            end
            READ: begin
                if (granted_empty && !STRICT_PRIO) rr_ptr_d = next_ptr;
            end
            CAPTURE: begin
                out_data_d  = fifo_q[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                out_valid_d = 1'b1;
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
            HOLD: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    if (keep_burst) begin
                        read_en_d = grant_onehot;
                    end else if (!STRICT_PRIO) begin
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: ;
        endcase
    end

    assign read_enable = read_en_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: four normal-mode fifo models feed the
// arbiter; a table drives the multi-grant drain, hand sequences cover stalls,
// external drain and mid-burst reset.
module tb_fifo_drain_arbiter;
    localparam int DW = 32;
    localparam int NQ = 4;
    localparam int QB = 2;
    localparam int DEPTH = 64;
    localparam int NVEC = 40;

    typedef struct {
        int          ready_delay;
        logic [QB-1:0] exp_grant;
        logic [DW-1:0] exp_data;
        int          exp_wait;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NQ-1:0]     fifo_empty;
    logic [NQ*DW-1:0]  fifo_q;
    logic [NQ-1:0]     read_enable;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [QB-1:0]     grant_id;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int last_re_cycle = -1;
    bit track_spacing = 1'b0;
    int re_hits [NQ] = '{default: 0};

    // Fifo models: registered q, pop on read_enable when non-empty.
    logic [DW-1:0] mem   [NQ][DEPTH];
    logic [DW-1:0] q_r   [NQ] = '{default: '0};
    int            rd_ptr [NQ] = '{default: 0};
    int            wr_cnt [NQ] = '{default: 0};

    fifo_drain_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_QUEUES (NQ),
        .QUEUE_BITS (QB),
        .MAX_BURST  (4),
        .BURST_BITS (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_q      (fifo_q),
        .read_enable (read_enable),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int i = 0; i < NQ; i++) begin
            if (read_enable[i] && rd_ptr[i] != wr_cnt[i]) begin
                q_r[i]    <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            fifo_empty[i]       = (rd_ptr[i] == wr_cnt[i]);
            fifo_q[i*DW +: DW]  = q_r[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_val(input int q, input int k);
        return 32'h5A00_0000 + DW'(q * 256 + k);
    endfunction

    task automatic push(input int q, input logic [DW-1:0] w);
        mem[q][wr_cnt[q]] = w;
        wr_cnt[q]++;
    endtask

    // Advance one cycle and sample at the falling edge; audit any read pulse.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cycle++;
        if (read_enable != '0) begin
            check("re_onehot_nonempty", {59'd0, read_enable & fifo_empty, $onehot(read_enable)}, 64'd1);
            for (int i = 0; i < NQ; i++) begin
                if (read_enable[i]) re_hits[i]++;
            end
            if (track_spacing) begin
                check("re_target", 64'(read_enable), 64'h4);
                if (last_re_cycle >= 0) check("re_spacing", 64'(cycle - last_re_cycle), 64'd3);
                last_re_cycle = cycle;
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) check({name, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic expect_word(input string name, input logic [QB-1:0] g, input logic [DW-1:0] d,
                               input int wait_exp, input int delay);
        int n;
        out_ready = (delay == 0);
        wait_valid(name, n);
        check({name, "_grant"}, 64'(grant_id), 64'(g));
        check({name, "_data"}, 64'(out_data), 64'(d));
        if (wait_exp >= 0) check({name, "_wait"}, 64'(n), 64'(wait_exp));
        for (int t = 0; t < delay; t++) begin
            tick();
            check({name, "_stall"}, 64'({out_valid, read_enable, out_data}), 64'({1'b1, 4'b0000, d}));
        end
        out_ready = 1'b1;
        tick();
        check({name, "_accept"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        vec_t vecs [NVEC];
        int   n;
        int   hits1_before;

        // Drain of 10 words per fifo with MAX_BURST=4: three rounds, the last
        // one cut short after 2 words by the fifos running empty.
        for (int j = 0; j < NVEC; j++) begin
            int g;
            int k;
            if (j < 32) begin
                g = (j / 4) % 4;
                k = (j / 16) * 4 + (j % 4);
            end else begin
                g = (j - 32) / 2;
                k = 8 + (j - 32) % 2;
            end
            vecs[j].exp_grant   = QB'(g);
            vecs[j].exp_data    = word_val(g, k);
            vecs[j].ready_delay = (j == 5) ? 5 : 0;
            vecs[j].exp_wait    = (j == 0 || vecs[j-1].exp_grant != QB'(g)) ? 3 : 2;
        end

        // Reset with all fifos empty, then idle.
        do_reset(2);
        check("t1_reset_outputs", 64'({busy, out_valid, read_enable, grant_id, out_data}), 64'd0);
        for (int t = 0; t < 8; t++) begin
            tick();
            check($sformatf("t1_idle_%0d", t), 64'({busy, out_valid, read_enable}), 64'd0);
        end

        // Single fifo with three words: pulses three cycles apart to fifo 2.
        out_ready = 1'b1;
        track_spacing = 1'b1;
        push(2, 32'hA1);
        push(2, 32'hA2);
        push(2, 32'hA3);
        expect_word("t2_w0", 2, 32'hA1, 3, 0);
        expect_word("t2_w1", 2, 32'hA2, 2, 0);
        expect_word("t2_w2", 2, 32'hA3, 2, 0);
        track_spacing = 1'b0;
        check("t2_pulses", 64'(re_hits[2]), 64'd3);
        repeat (3) tick();
        check("t2_idle", 64'(busy), 64'd0);

        // rr_ptr now points at 3: fifo 3 wins over fifo 0.
        push(0, 32'hF0);
        push(3, 32'hF3);
        expect_word("t2b_first", 3, 32'hF3, 3, 0);
        expect_word("t2b_second", 0, 32'hF0, 3, 0);

        // Full drain from a fresh reset, with a 5-cycle stall on record 5.
        do_reset(2);
        for (int q = 0; q < NQ; q++) begin
            for (int k = 0; k < 10; k++) push(q, word_val(q, k));
        end
        for (int j = 0; j < NVEC; j++) begin
            expect_word($sformatf("t3_v%0d", j), vecs[j].exp_grant, vecs[j].exp_data,
                        vecs[j].exp_wait, vecs[j].ready_delay);
        end

        // Fifo 1 drained externally while its second word is held.
        hits1_before = re_hits[1];
        for (int k = 0; k < 4; k++) push(1, 32'hB0 + DW'(k));
        push(2, 32'hC0);
        push(2, 32'hC1);
        expect_word("t5_b0", 1, 32'hB0, 3, 0);
        out_ready = 1'b0;
        wait_valid("t5_b1", n);
        check("t5_b1_grant", 64'(grant_id), 64'd1);
        check("t5_b1_data", 64'(out_data), 64'hB1);
        wr_cnt[1] = rd_ptr[1];
        tick();
        check("t5_b1_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        check("t5_b1_accept", 64'(out_valid), 64'd0);
        expect_word("t5_c0", 2, 32'hC0, 3, 0);
        expect_word("t5_c1", 2, 32'hC1, 2, 0);
        check("t5_fifo1_pulses", 64'(re_hits[1] - hits1_before), 64'd2);

        // Reset while holding a word from fifo 3; search restarts at 0.
        push(3, 32'hD0);
        push(3, 32'hD1);
        push(0, 32'hE0);
        out_ready = 1'b0;
        wait_valid("t6_hold", n);
        check("t6_hold_grant", 64'(grant_id), 64'd3);
        check("t6_hold_data", 64'(out_data), 64'hD0);
        reset = 1'b1;
        tick();
        check("t6_reset_outputs", 64'({out_valid, grant_id, busy, read_enable, out_data}), 64'd0);
        reset = 1'b0;
        expect_word("t6_restart", 0, 32'hE0, 3, 0);
        expect_word("t6_next", 3, 32'hD1, 3, 0);
        repeat (3) tick();
        check("final_idle", 64'({busy, out_valid, read_enable}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Shares one downstream consumer between NUM_QUEUES fifo instances.
- Selects a non-empty fifo by round-robin and issues single-cycle read_enable pulses to it.
- Captures the fifo q word and presents it on a valid/ready output port.
- Bounds each grant to MAX_BURST words so no fifo can starve the others.

Parameters:
- DATA_WIDTH, 32, word width; matches the fifo DATA_WIDTH.
- NUM_QUEUES, 4, number of fifos arbitrated.
- QUEUE_BITS, 2, width of queue index; clog2(NUM_QUEUES).
- MAX_BURST, 4, maximum words drained per grant (1 to 7).
- BURST_BITS, 3, width of the burst counter.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- fifo_empty  input  NUM_QUEUES  bit i is fifo i fifo_empty.
- fifo_q  input  NUM_QUEUES*DATA_WIDTH  fifo i q at bits [i*DATA_WIDTH +: DATA_WIDTH].
- read_enable  output  NUM_QUEUES  one-hot read pulse to fifo i.
- out_data  output  DATA_WIDTH  captured word.
- out_valid  output  1  out_data valid; held until accepted.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- grant_id  output  QUEUE_BITS  index of the currently granted fifo.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, checked before any other assignment):
  - state=IDLE, rr_ptr=0, burst_cnt=0.
  - read_enable=0, out_data=0, out_valid=0, grant_id=0, busy=0.
- States: IDLE, READ, CAPTURE, HOLD.
- IDLE:
  - Search the fifos from rr_ptr upward, wrapping modulo NUM_QUEUES, for the first i with fifo_empty[i]=0.
  - If one is found: grant_id<=i, burst_cnt<=0, go to READ. Otherwise stay in IDLE.
- READ:
  - read_enable[grant_id]=1 for exactly this one cycle; it is a registered output.
  - If fifo_empty[grant_id]=1 on entry (the fifo drained externally), skip the pulse and go to ROTATE handling (see below).
  - Otherwise go to CAPTURE.
- CAPTURE:
  - out_data<=fifo_q[grant_id], out_valid<=1, burst_cnt<=burst_cnt+1, go to HOLD.
- HOLD:
  - out_valid stays high and out_data is stable until out_ready=1.
  - On acceptance, out_valid<=0. Then:
    - If burst_cnt<MAX_BURST and fifo_empty[grant_id]=0, go to READ.
    - Otherwise ROTATE: rr_ptr<=grant_id+1 (wraps to 0 past NUM_QUEUES-1), go to IDLE.
- Latency: grant to out_valid is 2 cycles. Minimum period is 3 cycles per word with out_ready held high.
- Simultaneous out_ready in the same cycle out_valid rises: the word is accepted at the next edge only (out_valid must be registered high first).
- Empty boundary: never pulse read_enable to a fifo whose fifo_empty=1.
- read_enable is one-hot or zero in every cycle.
- fifo_empty asserting in HOLD forces ROTATE after acceptance.
- Wrap-around: rr_ptr arithmetic is modulo NUM_QUEUES. Handle non-power-of-two NUM_QUEUES explicitly.
- Reset mid-burst: the captured word is discarded and out_valid drops at the reset edge. Fifo pointers are not touched by this block.
- All fifos empty: the block stays in IDLE with busy=0.

Optional Feature:
- Macro FIFO_ARB_STRICT_PRIO_EN.
- Defined: the IDLE search always starts at index 0 (fifo 0 highest priority). rr_ptr is not updated. MAX_BURST still limits the grant, after which arbitration re-runs.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - the state encoding constants (IDLE=2'd0, READ=2'd1, CAPTURE=2'd2, HOLD=2'd3);
  - the default widths DATA_WIDTH and QUEUE_BITS.
- Sub-module rr_select: combinational. Inputs are the request vector (~fifo_empty) and the start index. Outputs are found and index.
  - Reused by other arbiters in the design.

Test Plan:
1. Reset held 2 cycles, all fifo_empty=1 -> outputs zero, busy=0, state IDLE indefinitely, no read_enable.
2. Only fifo 2 non-empty with 3 words (0xA1, 0xA2, 0xA3), out_ready=1 -> read_enable=4'b0100 pulses 3 times, 3 cycles apart. out_data sequence A1, A2, A3. Then IDLE with rr_ptr=3.
3. All 4 fifos non-empty with 10 words each, MAX_BURST=4 -> grant_id sequence 0,1,2,3,0, with 4 words per grant. No fifo granted twice before the others.
4. out_ready held low 5 cycles during HOLD -> out_valid stays 1, out_data stable, no further read_enable. Resumes READ after acceptance.
5. fifo 1 goes empty after 2 of MAX_BURST words -> ROTATE to the next non-empty fifo. read_enable never asserted while fifo_empty[1]=1.
6. Reset pulsed during HOLD with out_valid=1 -> out_valid=0, grant_id=0 at the next edge. A new grant starts from index 0.
